// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - requester and memory-controller signal bundle for mem_req_arbiter
interface mem_req_arbiter_if;
    logic        rdy_in;
    logic        flush_in;

    logic        ic_req_in;
    logic [31:0] ic_addr_in;
    logic        ic_grant_out;
    logic        ic_done_out;

    logic        lsb_req_in;
    logic [31:0] lsb_addr_in;
    logic [31:0] lsb_data_in;
    logic        lsb_r_nw_in;
    logic [2:0]  lsb_type_in;
    logic        lsb_grant_out;
    logic        lsb_done_out;

    logic [31:0] rdata_out;

    logic        mc_activate_out;
    logic [31:0] mc_addr_out;
    logic [31:0] mc_data_out;
    logic        mc_r_nw_out;
    logic [2:0]  mc_type_out;
    logic [1:0]  mc_src_out;
    logic [31:0] mc_data_in;
    logic        mc_done_in;

    modport slave (
        input  rdy_in, flush_in,
        input  ic_req_in, ic_addr_in,
        input  lsb_req_in, lsb_addr_in, lsb_data_in, lsb_r_nw_in, lsb_type_in,
        input  mc_data_in, mc_done_in,
        output ic_grant_out, ic_done_out, lsb_grant_out, lsb_done_out, rdata_out,
        output mc_activate_out, mc_addr_out, mc_data_out, mc_r_nw_out, mc_type_out, mc_src_out
    );

    modport master (
        output rdy_in, flush_in,
        output ic_req_in, ic_addr_in,
        output lsb_req_in, lsb_addr_in, lsb_data_in, lsb_r_nw_in, lsb_type_in,
        output mc_data_in, mc_done_in,
        input  ic_grant_out, ic_done_out, lsb_grant_out, lsb_done_out, rdata_out,
        input  mc_activate_out, mc_addr_out, mc_data_out, mc_r_nw_out, mc_type_out, mc_src_out
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - icache/LSB arbiter for a single-port memory controller; ARB_STARVE_GUARD_EN enables the icache starvation guard
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    mem_req_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_LSB  = 2'b01;
    localparam logic [1:0] SRC_IC   = 2'b10;

    // Counter must be able to represent the limit
    if (CNT_W < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << CNT_W)) begin : g_bad_params
        $error("mem_req_arbiter: STARVE_LIMIT does not fit in CNT_W bits");
    end

    state_t state;
    logic   cool;      // completion cycle: no arbitration, owner's request is masked
    logic   discard;   // in-flight icache result must be dropped
    logic   starve;    // icache has waited too long, it wins the next arbitration
    logic   pick_ic;
    logic   pick_lsb;

    // Arbitration decision for the current IDLE cycle
    always_comb begin
        pick_ic  = 1'b0;
        pick_lsb = 1'b0;
        if (state == IDLE && !cool) begin
            if (starve && bus.ic_req_in) begin
                pick_ic = 1'b1;
            end else if (bus.lsb_req_in) begin
                pick_lsb = 1'b1;
            end else if (bus.ic_req_in) begin
                pick_ic = 1'b1;
            end
        end
    end

    // Main IDLE/BUSY controller with registered outputs
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state               <= IDLE;
            cool                <= 1'b0;
            discard             <= 1'b0;
            bus.ic_grant_out    <= 1'b0;
            bus.ic_done_out     <= 1'b0;
            bus.lsb_grant_out   <= 1'b0;
            bus.lsb_done_out    <= 1'b0;
            bus.rdata_out       <= 32'h0;
            bus.mc_activate_out <= 1'b0;
            bus.mc_addr_out     <= 32'h0;
            bus.mc_data_out     <= 32'h0;
            bus.mc_r_nw_out     <= 1'b1;
            bus.mc_type_out     <= 3'b000;
            bus.mc_src_out      <= SRC_NONE;
        end else if (bus.rdy_in) begin
            bus.ic_grant_out  <= 1'b0;
            bus.ic_done_out   <= 1'b0;
            bus.lsb_grant_out <= 1'b0;
            bus.lsb_done_out  <= 1'b0;
            cool              <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_lsb) begin
                        bus.lsb_grant_out   <= 1'b1;
                        bus.mc_activate_out <= 1'b1;
                        bus.mc_addr_out     <= bus.lsb_addr_in;
                        bus.mc_data_out     <= bus.lsb_data_in;
                        bus.mc_r_nw_out     <= bus.lsb_r_nw_in;
                        bus.mc_type_out     <= bus.lsb_type_in;
                        bus.mc_src_out      <= SRC_LSB;
                        state               <= BUSY;
                    end else if (pick_ic) begin
                        bus.ic_grant_out    <= 1'b1;
                        bus.mc_activate_out <= 1'b1;
                        bus.mc_addr_out     <= bus.ic_addr_in;
                        bus.mc_data_out     <= 32'h0;
                        bus.mc_r_nw_out     <= 1'b1;
                        bus.mc_type_out     <= 3'b000;
                        bus.mc_src_out      <= SRC_IC;
                        state               <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mc_src_out == SRC_IC && bus.flush_in) begin
                        discard <= 1'b1;
                    end
                    if (bus.mc_done_in) begin
                        state               <= IDLE;
                        cool                <= 1'b1;
                        discard             <= 1'b0;
                        bus.mc_activate_out <= 1'b0;
                        bus.mc_src_out      <= SRC_NONE;
                        bus.mc_r_nw_out     <= 1'b1;
                        if (bus.mc_src_out == SRC_IC) begin
                            // A flush arriving with the completion still drops it
                            if (!(discard || bus.flush_in)) begin
                                bus.ic_done_out <= 1'b1;
                                bus.rdata_out   <= bus.mc_data_in;
                            end
                        end else begin
                            bus.lsb_done_out <= 1'b1;
                            if (bus.mc_r_nw_out) begin
                                bus.rdata_out <= bus.mc_data_in;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] starve_cnt;

    // Count LSB wins that overtook a waiting icache request
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            starve_cnt <= '0;
            starve     <= 1'b0;
        end else if (bus.rdy_in) begin
            if ((state == IDLE && !bus.ic_req_in) || pick_ic) begin
                starve_cnt <= '0;
                starve     <= 1'b0;
            end else if (pick_lsb && bus.ic_req_in) begin
                starve_cnt <= starve_cnt + 1'b1;
                if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                    starve <= 1'b1;
                end
            end
        end
    end
`else
    assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed vector bench for mem_req_arbiter
module tb_mem_req_arbiter;

    typedef struct {
        string       name;
        logic        icr;
        logic [31:0] ica;
        logic        lr;
        logic [31:0] la;
        logic [31:0] ld;
        logic        lrnw;
        logic [2:0]  lt;
        logic        fl;
        logic [31:0] md;
        logic        mdone;
        logic [3:0]  pulses;   // {ic_grant, ic_done, lsb_grant, lsb_done}
        logic        act;
        logic [1:0]  src;
        logic        rnw;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] rdata;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mem_req_arbiter_if bus ();

    mem_req_arbiter dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [74:0] got, input logic [74:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic set_idle;
        bus.rdy_in      = 1'b1;
        bus.flush_in    = 1'b0;
        bus.ic_req_in   = 1'b0;
        bus.ic_addr_in  = 32'h0;
        bus.lsb_req_in  = 1'b0;
        bus.lsb_addr_in = 32'h0;
        bus.lsb_data_in = 32'h0;
        bus.lsb_r_nw_in = 1'b1;
        bus.lsb_type_in = 3'b000;
        bus.mc_data_in  = 32'h0;
        bus.mc_done_in  = 1'b0;
    endtask

    function automatic logic [74:0] snap();
        return {bus.ic_grant_out, bus.ic_done_out, bus.lsb_grant_out, bus.lsb_done_out,
                bus.mc_activate_out, bus.mc_src_out, bus.mc_r_nw_out, bus.mc_type_out,
                bus.mc_addr_out, bus.rdata_out};
    endfunction

    vec_t vecs [16];
    int   grants [$];
    int   ic_grants;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        set_idle();

        //                 name                 icr ica         lr la          ld            rnw lt      fl md            dn pulses   act src    rnw typ     addr         rdata
        vecs[0]  = '{"ic_req",             1, 32'h1000, 0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0,        0, 4'b1000, 1, 2'b10, 1, 3'b000, 32'h1000, 32'h0};
        vecs[1]  = '{"ic_busy1",           0, 32'h1000, 0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0,        0, 4'b0000, 1, 2'b10, 1, 3'b000, 32'h1000, 32'h0};
        vecs[2]  = '{"ic_busy2",           0, 32'h1000, 0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0,        0, 4'b0000, 1, 2'b10, 1, 3'b000, 32'h1000, 32'h0};
        vecs[3]  = '{"busy_ignores_lsb",   0, 32'h0,    1, 32'h2000, 32'h12345678, 0, 3'b000, 0, 32'h0,        0, 4'b0000, 1, 2'b10, 1, 3'b000, 32'h1000, 32'h0};
        vecs[4]  = '{"ic_done",            0, 32'h0,    1, 32'h2000, 32'h12345678, 0, 3'b000, 0, 32'hDEADBEEF, 1, 4'b0100, 0, 2'b00, 1, 3'b000, 32'h1000, 32'hDEADBEEF};
        vecs[5]  = '{"done_gap",           0, 32'h0,    1, 32'h2000, 32'h12345678, 0, 3'b000, 0, 32'h0,        0, 4'b0000, 0, 2'b00, 1, 3'b000, 32'h1000, 32'hDEADBEEF};
        vecs[6]  = '{"both_req_lsb_wins",  1, 32'h3000, 1, 32'h2000, 32'h12345678, 0, 3'b000, 0, 32'h0,        0, 4'b0010, 1, 2'b01, 0, 3'b000, 32'h2000, 32'hDEADBEEF};
        vecs[7]  = '{"lsb_busy",           1, 32'h3000, 0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0,        0, 4'b0000, 1, 2'b01, 0, 3'b000, 32'h2000, 32'hDEADBEEF};
        vecs[8]  = '{"lsb_wr_done",        1, 32'h3000, 0, 32'h0,    32'h0,        1, 3'b000, 0, 32'hAAAA5555, 1, 4'b0001, 0, 2'b00, 1, 3'b000, 32'h2000, 32'hDEADBEEF};
        vecs[9]  = '{"lsb_gap",            1, 32'h3000, 0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0,        0, 4'b0000, 0, 2'b00, 1, 3'b000, 32'h2000, 32'hDEADBEEF};
        vecs[10] = '{"ic_after_lsb",       1, 32'h3000, 0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0,        0, 4'b1000, 1, 2'b10, 1, 3'b000, 32'h3000, 32'hDEADBEEF};
        vecs[11] = '{"ic_done2",           0, 32'h0,    0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0BADF00D, 1, 4'b0100, 0, 2'b00, 1, 3'b000, 32'h3000, 32'h0BADF00D};
        vecs[12] = '{"flush_idle",         0, 32'h0,    0, 32'h0,    32'h0,        1, 3'b000, 1, 32'h0,        0, 4'b0000, 0, 2'b00, 1, 3'b000, 32'h3000, 32'h0BADF00D};
        vecs[13] = '{"lsb_rd_grant",       0, 32'h0,    1, 32'h44,   32'h0,        1, 3'b101, 0, 32'h0,        0, 4'b0010, 1, 2'b01, 1, 3'b101, 32'h44,   32'h0BADF00D};
        vecs[14] = '{"lsb_done_flush",     0, 32'h0,    0, 32'h0,    32'h0,        1, 3'b000, 1, 32'hFFFF8001, 1, 4'b0001, 0, 2'b00, 1, 3'b101, 32'h44,   32'hFFFF8001};
        vecs[15] = '{"idle_end",           0, 32'h0,    0, 32'h0,    32'h0,        1, 3'b000, 0, 32'h0,        0, 4'b0000, 0, 2'b00, 1, 3'b101, 32'h44,   32'hFFFF8001};

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_outputs", snap(), {4'b0000, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0});
        chk("reset_mc_data", {43'h0, bus.mc_data_out}, 75'h0);
        rst_n = 1'b1;

        // Table-driven main flow
        for (int i = 0; i < 16; i++) begin
            bus.ic_req_in   = vecs[i].icr;
            bus.ic_addr_in  = vecs[i].ica;
            bus.lsb_req_in  = vecs[i].lr;
            bus.lsb_addr_in = vecs[i].la;
            bus.lsb_data_in = vecs[i].ld;
            bus.lsb_r_nw_in = vecs[i].lrnw;
            bus.lsb_type_in = vecs[i].lt;
            bus.flush_in    = vecs[i].fl;
            bus.mc_data_in  = vecs[i].md;
            bus.mc_done_in  = vecs[i].mdone;
            tick();
            chk(vecs[i].name, snap(), {vecs[i].pulses, vecs[i].act, vecs[i].src, vecs[i].rnw,
                                       vecs[i].typ, vecs[i].addr, vecs[i].rdata});
            if (vecs[i].pulses[1]) begin
                chk("lsb_store_data", {43'h0, bus.mc_data_out}, {43'h0, vecs[i].ld});
            end
        end
        set_idle();

        // rdy_in low during BUSY and during a done pulse
        bus.ic_req_in  = 1'b1;
        bus.ic_addr_in = 32'h5000;
        tick();
        chk("rdy_grant", snap(), {4'b1000, 1'b1, 2'b10, 1'b1, 3'b000, 32'h5000, 32'hFFFF8001});
        bus.ic_req_in = 1'b0;
        bus.rdy_in    = 1'b0;
        repeat (3) tick();
        chk("rdy_grant_stretched", snap(), {4'b1000, 1'b1, 2'b10, 1'b1, 3'b000, 32'h5000, 32'hFFFF8001});
        bus.rdy_in = 1'b1;
        tick();
        chk("rdy_grant_released", snap(), {4'b0000, 1'b1, 2'b10, 1'b1, 3'b000, 32'h5000, 32'hFFFF8001});
        bus.mc_done_in = 1'b1;
        bus.mc_data_in = 32'hCAFE0001;
        tick();
        chk("rdy_done", snap(), {4'b0100, 1'b0, 2'b00, 1'b1, 3'b000, 32'h5000, 32'hCAFE0001});
        bus.mc_done_in = 1'b0;
        bus.mc_data_in = 32'h0;
        bus.rdy_in     = 1'b0;
        repeat (3) tick();
        chk("rdy_done_stretched", snap(), {4'b0100, 1'b0, 2'b00, 1'b1, 3'b000, 32'h5000, 32'hCAFE0001});
        bus.rdy_in = 1'b1;
        tick();
        chk("rdy_done_released", snap(), {4'b0000, 1'b0, 2'b00, 1'b1, 3'b000, 32'h5000, 32'hCAFE0001});

        // Flush in the middle of an icache transfer
        bus.ic_req_in  = 1'b1;
        bus.ic_addr_in = 32'h6000;
        tick();
        bus.ic_req_in = 1'b0;
        bus.flush_in  = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        tick();
        bus.mc_done_in = 1'b1;
        bus.mc_data_in = 32'h11111111;
        tick();
        chk("flush_mid_done", snap(), {4'b0000, 1'b0, 2'b00, 1'b1, 3'b000, 32'h6000, 32'hCAFE0001});
        bus.mc_done_in = 1'b0;
        tick();
        bus.ic_req_in  = 1'b1;
        bus.ic_addr_in = 32'h6004;
        tick();
        chk("flush_next_grant", snap(), {4'b1000, 1'b1, 2'b10, 1'b1, 3'b000, 32'h6004, 32'hCAFE0001});
        bus.ic_req_in  = 1'b0;
        bus.mc_done_in = 1'b1;
        bus.mc_data_in = 32'h22222222;
        tick();
        chk("flush_next_done", snap(), {4'b0100, 1'b0, 2'b00, 1'b1, 3'b000, 32'h6004, 32'h22222222});
        bus.mc_done_in = 1'b0;
        tick();

        // Flush coincident with the completion
        bus.ic_req_in  = 1'b1;
        bus.ic_addr_in = 32'h7000;
        tick();
        bus.ic_req_in = 1'b0;
        tick();
        bus.flush_in   = 1'b1;
        bus.mc_done_in = 1'b1;
        bus.mc_data_in = 32'h33333333;
        tick();
        chk("flush_coincident", snap(), {4'b0000, 1'b0, 2'b00, 1'b1, 3'b000, 32'h7000, 32'h22222222});
        bus.flush_in   = 1'b0;
        bus.mc_done_in = 1'b0;
        tick();
        bus.ic_req_in  = 1'b1;
        bus.ic_addr_in = 32'h7004;
        tick();
        chk("flush2_next_grant", snap(), {4'b1000, 1'b1, 2'b10, 1'b1, 3'b000, 32'h7004, 32'h22222222});
        bus.ic_req_in  = 1'b0;
        bus.mc_done_in = 1'b1;
        bus.mc_data_in = 32'h44444444;
        tick();
        chk("flush2_next_done", snap(), {4'b0100, 1'b0, 2'b00, 1'b1, 3'b000, 32'h7004, 32'h44444444});
        bus.mc_done_in = 1'b0;
        tick();

        // Both requesters held continuously; controller completes at once
        bus.ic_req_in   = 1'b1;
        bus.ic_addr_in  = 32'h8000;
        bus.lsb_req_in  = 1'b1;
        bus.lsb_addr_in = 32'h9000;
        bus.lsb_r_nw_in = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bus.mc_done_in = bus.mc_activate_out;
            tick();
            if (bus.lsb_grant_out) grants.push_back(1);
            if (bus.ic_grant_out)  grants.push_back(2);
        end
        set_idle();
        for (int c = 0; c < 4; c++) begin
            bus.mc_done_in = bus.mc_activate_out;
            tick();
        end
        bus.mc_done_in = 1'b0;
        tick();
        chk("starve_grant_count", {74'h0, grants.size() >= 6}, 75'h1);
        ic_grants = 0;
        foreach (grants[k]) if (grants[k] == 2) ic_grants++;
`ifdef ARB_STARVE_GUARD_EN
        if (grants.size() >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("starve_seq_%0d", k), 75'(grants[k]), (k == 4) ? 75'd2 : 75'd1);
            end
        end
        chk("starve_ic_served", {74'h0, ic_grants >= 1}, 75'h1);
`else
        chk("strict_no_ic_grant", 75'(ic_grants), 75'd0);
`endif

        // Asynchronous reset in the middle of a transfer
        bus.ic_req_in  = 1'b1;
        bus.ic_addr_in = 32'hA000;
        tick();
        bus.ic_req_in = 1'b0;
        tick();
        chk("pre_reset_busy", {74'h0, bus.mc_activate_out}, 75'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", snap(), {4'b0000, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0});
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", snap(), {4'b0000, 1'b0, 2'b00, 1'b1, 3'b000, 32'h0, 32'h0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

- Arbitrates the single-port memory controller between the instruction cache and the load/store buffer.
- Accepts one request at a time, latches its fields, and holds them stable toward the controller until the controller reports completion.
- Returns read data to the owning requester with a one-cycle done pulse.
- Fixed LSB-first priority, with an optional starvation guard for the icache and a flush that discards in-flight icache results.

## Interface
- STARVE_LIMIT, 4: consecutive LSB grants tolerated while icache waits.
- CNT_W, 3: starvation counter width; must hold STARVE_LIMIT.
- clk_in  in  1  clock, all state on rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; low freezes all state and outputs
- ic_req_in  in  1  icache request (read, word)
- ic_addr_in  in  32  icache address
- ic_grant_out  out  1  one-cycle pulse: icache request accepted
- ic_done_out  out  1  one-cycle pulse: icache rdata_out valid
- lsb_req_in  in  1  LSB request
- lsb_addr_in / lsb_data_in  in  32/32  LSB address / store data
- lsb_r_nw_in  in  1  1 read, 0 write
- lsb_type_in  in  3  [1:0] 00 word / 01 half / 10 byte; [2] signed
- lsb_grant_out / lsb_done_out  out  1/1  as icache counterparts
- rdata_out  out  32  read data of the last completed transfer
- flush_in  in  1  discard any in-flight icache result
- mc_activate_out  out  1  request valid toward controller
- mc_addr_out / mc_data_out  out  32/32  latched address / store data
- mc_r_nw_out  out  1  latched direction
- mc_type_out  out  3  latched type; 3'b000 for icache
- mc_src_out  out  2  00 none, 01 LSB, 10 icache
- mc_data_in  in  32  controller read data
- mc_done_in  in  1  controller completion pulse

## Operation
- States are IDLE and BUSY.
- IDLE:
  - Arbitrate among requests. Winner fields are latched into the mc_* registers; the winner's grant pulses; the state moves to BUSY with mc_activate_out=1.
  - Priority: LSB over icache, unless the starvation flag is set (see Configuration). In that case icache wins.
- BUSY:
  - mc_* outputs are held constant and request inputs are ignored.
  - On mc_done_in: latch mc_data_in into rdata_out (for reads only; writes leave rdata_out unchanged). Pulse the owner's done. Clear mc_activate_out and mc_src_out. Set mc_r_nw_out=1 and move to IDLE.
- In the cycle its done is high, the just-completed owner's request is masked. A request still high on the following cycle is a new request.
- Flush:
  - flush_in in BUSY with icache owner sets a sticky discard flag. This includes flush_in in the same cycle as mc_done_in.
  - The transfer still runs to mc_done_in, because memory cannot abort. ic_done_out is suppressed and rdata_out is not updated. The flag clears on return to IDLE.
  - flush_in in IDLE, or with LSB owner, has no effect.
- Simultaneous ic_req_in and lsb_req_in in IDLE: LSB wins, unless the starvation flag is set.

## Timing
- Reset values:
  - State IDLE.
  - All *_out are 0, except mc_r_nw_out=1.
  - Counter, starvation flag and discard flag are 0.
- Reset is honoured mid-transfer: BUSY is abandoned immediately.
- Request in IDLE at edge T:
  - grant and mc_activate_out are high after edge T.
  - The grant pulse lasts one cycle.
- mc_done_in high in cycle D:
  - done_out and rdata_out are valid after edge D for one cycle.
  - The state is IDLE in that cycle.
- Minimum issue-to-issue spacing is 1 IDLE cycle after done.
- rdy_in low: no state change; pulses stretch until rdy_in returns high.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - The counter increments on each LSB grant made while ic_req_in=1.
  - When the count reaches STARVE_LIMIT, the starvation flag is set and the next arbitration grants icache.
  - The counter clears on icache grant or whenever ic_req_in=0 in IDLE.
- ARB_STARVE_GUARD_EN undefined: strict LSB priority; no counter logic.

## Test plan
- Single icache read: ic_addr_in=0x1000, mc_done_in 4 cycles after activate with mc_data_in=0xDEADBEEF -> ic_grant_out one pulse, mc_src_out=10, ic_done_out one pulse with rdata_out=0xDEADBEEF.
- Simultaneous requests: LSB SW addr=0x2000 data=0x12345678 plus icache read -> LSB served first (mc_type_out=000, mc_r_nw_out=0), then icache granted 1 cycle after lsb_done_out.
- Starvation (macro on, STARVE_LIMIT=4): LSB and icache requests held continuously -> 4 LSB grants, then an icache grant, then LSB again; with the macro off, icache is never granted.
- Flush: flush_in pulsed mid icache transfer, and separately coincident with mc_done_in -> no ic_done_out, rdata_out keeps its old value, next request is accepted normally.
- rdy_in low for 3 cycles during BUSY and during a done pulse -> outputs frozen, pulse stretched, no lost completion.
- Async reset asserted mid-BUSY -> all outputs return to reset values without a clock edge.
